// File: rtl/nbit_pkg.sv
// -----------------------------------------------------------------------------
// nbit_pkg
//
// Shared definitions for the n-bit burst accumulator:
//   - state_e        : FSM state encoding (ACCUM collects operands, DONE holds
//                      the result until the consumer takes it)
//   - sat_max/sat_min: saturation limits for a given width and signedness,
//                      returned as MaxSatW-bit patterns for the caller to
//                      truncate to its own width
// -----------------------------------------------------------------------------
package nbit_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    // Widest accumulator the limit helpers can describe.
    localparam int unsigned MaxSatW = 64;

    // Largest representable value: 2^w-1 unsigned, 2^(w-1)-1 signed.
    function automatic logic [MaxSatW-1:0] sat_max(input int unsigned width,
                                                   input bit          is_signed);
        logic [MaxSatW-1:0] ones;
        ones = '1;
        if (is_signed) begin
            return ones >> (MaxSatW - width + 1);
        end
        return ones >> (MaxSatW - width);
    endfunction

    // Smallest representable value: 0 unsigned, -2^(w-1) signed. The signed
    // case comes back sign-extended to MaxSatW bits, so truncation keeps it.
    function automatic logic [MaxSatW-1:0] sat_min(input int unsigned width,
                                                   input bit          is_signed);
        if (is_signed) begin
            return ~sat_max(width, 1'b1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/nbit_sat_add.sv
// -----------------------------------------------------------------------------
// nbit_sat_add
//
// Combinational accumulate step: sum = f(acc + addend), plus an overflow flag.
// Both addends are already ACC_W wide (the caller extends the operand).
//
// Parameters:
//   ACC_W    : accumulator width (at most nbit_pkg::MaxSatW)
//   SIGNED   : 1 = two's-complement, 0 = unsigned
//   SATURATE : 1 = clamp to the representable range on overflow, 0 = wrap
//
// Ports:
//   acc    in  ACC_W : current accumulator value
//   addend in  ACC_W : extended operand
//   sum    out ACC_W : next accumulator value
//   ovf    out 1     : this addition overflowed
// -----------------------------------------------------------------------------
module nbit_sat_add
    import nbit_pkg::*;
#(
    parameter int unsigned ACC_W    = 8,
    parameter bit          SIGNED   = 1'b0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] MaxVal = ACC_W'(sat_max(ACC_W, SIGNED));
    localparam logic [ACC_W-1:0] MinVal = ACC_W'(sat_min(ACC_W, SIGNED));

    // One extra bit keeps the unsigned carry-out.
    logic [ACC_W:0] raw;

    assign raw = {1'b0, acc} + {1'b0, addend};

    always_comb begin
        ovf = 1'b0;
        sum = raw[ACC_W-1:0];

        if (SIGNED) begin
            // Same-sign addends producing a different-sign result.
            ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            ovf = raw[ACC_W];
        end

        if (SATURATE && ovf) begin
            if (SIGNED) begin
                // Signed overflow direction follows the (shared) addend sign.
                sum = acc[ACC_W-1] ? MinVal : MaxVal;
            end else begin
                sum = MaxVal;
            end
        end
    end

endmodule

// File: rtl/nbit_accumulator.sv
// -----------------------------------------------------------------------------
// nbit_accumulator
//
// Sums a burst of LEN N-bit operands into an ACC_W-bit accumulator and offers
// one result per burst. Arithmetic is signed or unsigned, wrapping or
// saturating, as selected by parameter. Valid/ready on both sides.
//
// Parameters:
//   N        : operand width
//   ACC_W    : accumulator / result width, ACC_W >= N+1, ACC_W <= 64
//   LEN      : operands per burst, >= 1
//   SIGNED   : 1 = two's-complement operands and result
//   SATURATE : 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W
//
// Ports:
//   clk       in  1     : clock, rising edge
//   rst_n     in  1     : asynchronous active-low reset
//   clear     in  1     : synchronous abort, beats both handshakes
//   in_valid  in  1     : in_data is valid
//   in_ready  out 1     : an operand is accepted this cycle
//   in_data   in  N     : operand
//   out_valid out 1     : result available
//   out_ready in  1     : consumer takes the result
//   out_data  out ACC_W : burst sum (registered)
//   out_ovf   out 1     : sticky overflow for the burst (registered)
// -----------------------------------------------------------------------------
module nbit_accumulator
    import nbit_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned ACC_W    = 8,
    parameter int unsigned LEN      = 4,
    parameter bit          SIGNED   = 1'b0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int unsigned      CntW    = $clog2(LEN + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(LEN - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic              ovf_q,   ovf_d;

    logic [ACC_W-1:0]  ext_data;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic              beat;

    // Operand extension to accumulator width.
    always_comb begin
        ext_data = ACC_W'(in_data);
        if (SIGNED) begin
            ext_data = {{(ACC_W - N){in_data[N-1]}}, in_data};
        end
    end

    nbit_sat_add #(
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .acc    (acc_q),
        .addend (ext_data),
        .sum    (add_sum),
        .ovf    (add_ovf)
    );

    // in_ready depends only on state and clear, never on in_valid.
    assign in_ready  = (state_q == ACCUM) && !clear;
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        if (clear) begin
            // Abort: any partial burst or pending result is dropped.
            state_d = ACCUM;
            count_d = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (beat) begin
                        acc_d   = add_sum;
                        ovf_d   = ovf_q | add_ovf;
                        count_d = count_q + CntW'(1);
                        if (count_q == LastCnt) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        count_d = '0;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_nbit_accumulator.sv
module tb_nbit_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // dut0: default parameters
    logic       clear0, in_valid0, out_ready0;
    logic [3:0] in_data0;
    logic       in_ready0, out_valid0, out_ovf0;
    logic [7:0] out_data0;

    // dut1 (signed, saturate) and dut2 (unsigned, wrap) share one input bus
    logic       clear1, in_valid1, out_ready1;
    logic [3:0] in_data1;
    logic       in_ready1, out_valid1, out_ovf1;
    logic [5:0] out_data1;
    logic       in_ready2, out_valid2, out_ovf2;
    logic [5:0] out_data2;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t last0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          lat;

    nbit_accumulator dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear0),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_data  (out_data0),
        .out_ovf   (out_ovf0)
    );

    nbit_accumulator #(
        .N (4), .ACC_W (6), .LEN (8), .SIGNED (1'b1), .SATURATE (1'b1)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_ovf   (out_ovf1)
    );

    nbit_accumulator #(
        .N (4), .ACC_W (6), .LEN (8), .SIGNED (1'b0), .SATURATE (1'b0)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready2),
        .in_data   (in_data1),
        .out_valid (out_valid2),
        .out_ready (out_ready1),
        .out_data  (out_data2),
        .out_ovf   (out_ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: integer arithmetic with explicit range checks.
    function automatic logic [7:0] model(input int unsigned w, input bit sgn, input bit sat,
                                         input logic [3:0] ops[8], input int unsigned len,
                                         output bit ovf);
        longint acc, v, hi, lo, m, span;
        acc  = 0;
        ovf  = 1'b0;
        span = longint'(1) << w;
        if (sgn) begin
            hi = (longint'(1) << (w - 1)) - 1;
            lo = -(longint'(1) << (w - 1));
        end else begin
            hi = span - 1;
            lo = 0;
        end
        for (int i = 0; i < int'(len); i++) begin
            v = longint'(ops[i]);
            if (sgn && ops[i][3]) v = v - 16;
            acc = acc + v;
            if (acc > hi || acc < lo) begin
                ovf = 1'b1;
                if (sat) begin
                    acc = (acc > hi) ? hi : lo;
                end else begin
                    m = acc % span;
                    if (m < 0) m = m + span;
                    if (sgn && m > hi) m = m - span;
                    acc = m;
                end
            end
        end
        return 8'(acc & (span - 1));
    endfunction

    task automatic beat0(input logic [3:0] d);
        in_valid0 = 1'b1;
        in_data0  = d;
        @(negedge clk);
        chk("beat0_in_ready", in_ready0, 1);
        chk("beat0_out_valid", out_valid0, 0);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
    endtask

    task automatic burst0(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        logic [3:0] ops[8];
        exp_t e;
        bit o;
        ops = '{a, b, c, d, 4'h0, 4'h0, 4'h0, 4'h0};
        e.data = model(8, 1'b0, 1'b0, ops, 4, o);
        e.ovf  = o;
        q0.push_back(e);
        beat0(a); beat0(b); beat0(c); beat0(d);
    endtask

    task automatic wait_out0(input string tag, input bit handshake, output int latency);
        bit seen;
        seen    = 1'b0;
        latency = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid0) begin
                seen    = 1'b1;
                latency = i;
            end
        end
        chk({tag, "_valid_seen"}, seen, 1);
        if (seen) begin
            last0 = q0.pop_front();
            chk({tag, "_data"}, out_data0, last0.data);
            chk({tag, "_ovf"}, out_ovf0, last0.ovf);
            chk({tag, "_in_ready_done"}, in_ready0, 0);
        end
        if (handshake) begin
            out_ready0 = 1'b1;
            @(posedge clk); #1;
            out_ready0 = 1'b0;
            @(negedge clk);
            chk({tag, "_post_hs_in_ready"}, in_ready0, 1);
            chk({tag, "_post_hs_out_valid"}, out_valid0, 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic burst12(input logic [3:0] d);
        logic [3:0] ops[8];
        exp_t e;
        bit o;
        for (int i = 0; i < 8; i++) ops[i] = d;
        e.data = model(6, 1'b1, 1'b1, ops, 8, o);
        e.ovf  = o;
        q1.push_back(e);
        e.data = model(6, 1'b0, 1'b0, ops, 8, o);
        e.ovf  = o;
        q2.push_back(e);
        for (int i = 0; i < 8; i++) begin
            in_valid1 = 1'b1;
            in_data1  = d;
            @(negedge clk);
            chk("beat1_in_ready", in_ready1, 1);
            chk("beat2_in_ready", in_ready2, 1);
            @(posedge clk); #1;
            in_valid1 = 1'b0;
        end
    endtask

    task automatic wait_out12(input string tag);
        bit seen;
        exp_t e;
        int latency;
        seen    = 1'b0;
        latency = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid1) begin
                seen    = 1'b1;
                latency = i;
            end
        end
        chk({tag, "_valid_seen"}, seen, 1);
        chk({tag, "_latency"}, latency, 0);
        if (seen) begin
            chk({tag, "_dut2_valid"}, out_valid2, 1);
            e = q1.pop_front();
            chk({tag, "_signed_sat_data"}, out_data1, 32'(e.data));
            chk({tag, "_signed_sat_ovf"}, out_ovf1, e.ovf);
            e = q2.pop_front();
            chk({tag, "_unsigned_wrap_data"}, out_data2, 32'(e.data));
            chk({tag, "_unsigned_wrap_ovf"}, out_ovf2, e.ovf);
        end
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        clear0     = 1'b0;
        in_valid0  = 1'b0;
        in_data0   = '0;
        out_ready0 = 1'b0;
        clear1     = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_out_ovf", out_ovf0, 0);
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_dut1_out_valid", out_valid1, 0);
        clear0 = 1'b1;
        #1;
        chk("rst_clear_in_ready", in_ready0, 0);
        clear0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 15 x4 unsigned wrap, result visible the cycle after the last accept
        burst0(4'd15, 4'd15, 4'd15, 4'd15);
        wait_out0("t1", 1'b1, lat);
        chk("t1_latency", lat, 0);

        // 2/3: signed-saturate and unsigned-wrap in lockstep
        burst12(4'd7);
        wait_out12("t2_pos");
        burst12(4'h8);
        wait_out12("t2_neg");
        burst12(4'd15);
        wait_out12("t3");

        // 4: backpressure with an operand waiting
        burst0(4'd1, 4'd2, 4'd3, 4'd4);
        wait_out0("t4", 1'b0, lat);
        in_valid0 = 1'b1;
        in_data0  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_bp_out_valid", out_valid0, 1);
            chk("t4_bp_in_ready", in_ready0, 0);
            chk("t4_bp_data_stable", out_data0, last0.data);
            @(posedge clk); #1;
        end
        out_ready0 = 1'b1;
        @(negedge clk);
        chk("t4_hs_cycle_in_ready", in_ready0, 0);
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        in_valid0  = 1'b0;
        @(negedge clk);
        chk("t4_bubble_in_ready", in_ready0, 1);
        @(posedge clk); #1;
        burst0(4'd6, 4'd6, 4'd6, 4'd6);
        wait_out0("t4_next", 1'b1, lat);

        // 5: clear mid-burst drops the partial sum and refuses the operand
        beat0(4'd3);
        beat0(4'd4);
        clear0    = 1'b1;
        in_valid0 = 1'b1;
        in_data0  = 4'd9;
        @(negedge clk);
        chk("t5_clear_in_ready", in_ready0, 0);
        @(posedge clk); #1;
        clear0    = 1'b0;
        in_valid0 = 1'b0;
        burst0(4'd1, 4'd2, 4'd3, 4'd4);
        wait_out0("t5", 1'b1, lat);

        // clear in DONE discards the result without a handshake
        burst0(4'd2, 4'd2, 4'd2, 4'd2);
        wait_out0("t5_done", 1'b0, lat);
        clear0 = 1'b1;
        @(posedge clk); #1;
        clear0 = 1'b0;
        @(negedge clk);
        chk("t5_clear_done_out_valid", out_valid0, 0);
        chk("t5_clear_done_in_ready", in_ready0, 1);
        chk("t5_clear_done_out_data", out_data0, 0);
        @(posedge clk); #1;

        // 6: asynchronous reset while a result is pending
        burst0(4'd5, 4'd5, 4'd5, 4'd5);
        wait_out0("t6_pre", 1'b0, lat);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_out_valid", out_valid0, 0);
        chk("t6_async_out_data", out_data0, 0);
        chk("t6_async_out_ovf", out_ovf0, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        burst0(4'd1, 4'd1, 4'd1, 4'd1);
        wait_out0("t6", 1'b1, lat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
